// File: rtl/counter4bit_down.sv
// Loadable 4-bit down counter/timer with auto-reload and one-shot modes.
// Pin-compatible in output style with the lab's 4-bit up counter.
module counter4bit_down (
    input  logic       clk1,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       mode_in,
    input  logic       en,
    output logic [3:0] count,
    output logic       b0,
    output logic       b1,
    output logic       b2,
    output logic       b3,
    output logic       tc,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] count_q, count_n;
    logic [3:0] reload_q, reload_n;
    logic       mode_q, mode_n;
    logic       tc_q, tc_n;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= IDLE;
            count_q  <= 4'd0;
            reload_q <= 4'd0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state    <= state_n;
            count_q  <= count_n;
            reload_q <= reload_n;
            mode_q   <= mode_n;
            tc_q     <= tc_n;
        end
    end

    // Load beats counting; underflow either reloads or parks the one-shot in DONE.
    always_comb begin
        state_n  = state;
        count_n  = count_q;
        reload_n = reload_q;
        mode_n   = mode_q;
        tc_n     = 1'b0;
        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            mode_n   = mode_in;
            state_n  = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (count_q != 4'd0) begin
                            count_n = count_q - 4'd1;
                        end else begin
                            tc_n = 1'b1;
                            if (mode_q) begin
                                state_n = DONE;
                            end else begin
                                count_n = reload_q;
                            end
                        end
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    assign count = count_q;
    assign b0    = count_q[0];
    assign b1    = count_q[1];
    assign b2    = count_q[2];
    assign b3    = count_q[3];
    assign tc    = tc_q;
    // State is itself a flop, so these decodes change only on clk1 edges.
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: doc/counter4bit_down.md
Name: counter4bit_down

Overview:
Loadable 4-bit down counter/timer, the decrementing counterpart to the team's 4-bit up counter. It counts down from a loaded value and flags terminal count on underflow. Two modes: auto-reload (periodic tick generator) and one-shot (delay timer). Count is presented both as a 4-bit vector and as individual bit outputs, matching the up counter's output style so the two are interchangeable in lab top levels.

Parameters:
None. Datapath is fixed at 4 bits.

Ports:
clk1  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
load  input  1  load strobe; samples load_val and mode_in
load_val  input  4  start/reload value
mode_in  input  1  0 = auto-reload, 1 = one-shot; sampled only on load
en  input  1  count enable; one decrement step per enabled cycle
count  output  4  registered current count
b0, b1, b2, b3  output  1 each  registered copies of count[0]..count[3]
tc  output  1  registered terminal-count pulse, exactly one cycle per underflow event
busy  output  1  high in RUN
done  output  1  high in DONE (one-shot expired); sticky until load or rst

Behaviour:
- Clocking and priority: all outputs are registered and update on the rising edge of clk1. Per-edge priority is rst > load > en.
- Reset: sampled only on a clk1 edge. It overrides everything, including a mid-run count or a simultaneous load. Resulting values:
  - count = 0, b0..b3 = 0
  - tc = 0, busy = 0, done = 0
  - reload register = 0, latched mode = 0
  - state = IDLE
- Internal state: reload register reload_q[3:0], latched mode mode_q, FSM states IDLE / RUN / DONE.
- Load (any state):
  - count <= load_val; reload_q <= load_val; mode_q <= mode_in.
  - state <= RUN, done <= 0, tc <= 0.
  - en on the same cycle is ignored; no decrement occurs.
- IDLE: count holds, en ignored, tc = 0.
- RUN with en = 1 and count != 0: count <= count - 1, tc <= 0.
- RUN with en = 1 and count == 0 (underflow event):
  - mode_q = 0: count <= reload_q, tc <= 1, stay in RUN.
  - mode_q = 1: count holds 0, tc <= 1, state <= DONE, done <= 1.
- RUN with en = 0: count holds, tc <= 0.
- DONE: count holds 0, en ignored, tc = 0 after its single pulse, done = 1 until load or rst.
- Period and timing:
  - Auto-reload period is reload_q + 1 enabled cycles per tc.
  - reload_q = 0 in auto-reload gives tc on every enabled cycle, with count staying at 0.
  - A one-shot loaded with 0 pulses tc and sets done on its first enabled cycle.
- No wrap to 4'hF ever occurs; underflow always goes to reload_q (auto-reload) or holds 0 (one-shot).
- mode_in changes outside a load have no effect.
- b3..b0 equal count[3:0] on every cycle.
- Load in the same cycle as an underflow: load wins and tc stays 0.

Test Plan:
1. Reset check: assert rst for 2 cycles with load = 1, load_val = 9 also asserted. Required: count = 0, b0..b3 = 0, tc = 0, busy = 0, done = 0, state IDLE. en = 1 afterwards leaves count at 0.
2. One-shot, continuous count: load 5 with mode_in = 1 at edge E0, en = 1 from E1.
   - Count after edges E0..E5: 5, 4, 3, 2, 1, 0.
   - At E6: tc = 1 for one cycle, done = 1, busy = 0.
   - E7 onward: count stays 0, tc = 0, done stays 1.
3. Auto-reload: load 3 with mode_in = 0, en = 1 continuous.
   - Count sequence: 3, 2, 1, 0, 3, 2, 1, 0, 3, ...
   - tc = 1 exactly in the cycles where count returns to 3 after 0 (every 4th cycle).
   - b3..b0 match count throughout.
4. Enable gaps: same as scenario 3 but en toggles 1, 0, 1, 0. Count decrements only after enabled edges, and tc spacing stretches to 4 enabled cycles.
5. Interruptions:
   - Load 7 in auto-reload mid-run on the same cycle count == 0 with en = 1: count becomes 7 and tc = 0.
   - Later assert rst mid-run at count = 4: count = 0, busy = 0 on the next edge.
6. Zero reload:
   - Load 0 in auto-reload with en = 1: tc = 1 every cycle and count stays 0.
   - Load 0 in one-shot: a single tc pulse, then done = 1.
